// File: rtl/lc4_ooo_pkg.sv
// Shared sizing and reset constants for the LC4 out-of-order rename logic.
// Revision: 1.0
`default_nettype none

package lc4_ooo_pkg;

  localparam int NA = 8;
  localparam int NP = 16;
  localparam int AW = $clog2(NA);
  localparam int PW = $clog2(NP);

  typedef logic [AW-1:0] areg_t;
  typedef logic [PW-1:0] preg_t;

  function automatic logic [NA*PW-1:0] identity_map();
    logic [NA*PW-1:0] v;
    v = '0;
    for (int i = 0; i < NA; i++) begin
      v[i*PW +: PW] = PW'(i);
    end
    return v;
  endfunction

  // Architectural register i maps to physical register i out of reset.
  localparam logic [NA*PW-1:0] IDENTITY_MAP = identity_map();

endpackage

`default_nettype wire

// File: rtl/lc4_map_table.sv
// Architectural-to-physical map: NA x PW registers, three async read ports,
// one write port and a whole-table bulk load. Revision: 1.0
`default_nettype none

module lc4_map_table
  import lc4_ooo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [NA*PW-1:0]  load_data,
  input  logic              we,
  input  areg_t             waddr,
  input  preg_t             wdata,
  input  areg_t             raddr0,
  input  areg_t             raddr1,
  input  areg_t             raddr2,
  output preg_t             rdata0,
  output preg_t             rdata1,
  output preg_t             rdata2,
  output logic [NA*PW-1:0]  contents
);

  preg_t mem [NA];

  // Bulk load takes priority; the owner never asserts both in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NA; i++) begin
        mem[i] <= IDENTITY_MAP[i*PW +: PW];
      end
    end else if (load) begin
      for (int i = 0; i < NA; i++) begin
        mem[i] <= load_data[i*PW +: PW];
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

  generate
    for (genvar g = 0; g < NA; g++) begin : g_flat
      assign contents[g*PW +: PW] = mem[g];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/lc4_rename_table.sv
// LC4 rename stage: speculative and committed map tables, free-list handshake
// and a one-entry output register. Revision: 1.0
`default_nettype none

module lc4_rename_table
  import lc4_ooo_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  gwe,
  input  logic  flush,
  input  logic  rn_valid,
  input  areg_t rn_rs1,
  input  areg_t rn_rs2,
  input  areg_t rn_rd,
  input  logic  rn_rd_we,
  output logic  rn_ready,
  input  preg_t fl_next,
  input  logic  fl_full,
  output logic  fl_alloc,
  output logic  out_valid,
  input  logic  out_stall,
  output preg_t out_ps1,
  output preg_t out_ps2,
  output preg_t out_pd,
  output preg_t out_old_pd,
  output logic  out_rd_we,
  input  logic  cm_valid,
  input  areg_t cm_rd,
  input  preg_t cm_pd,
  input  logic  cm_rd_we,
  output logic  fl_dealloc,
  output preg_t fl_cpr
);

  logic             slot_free;
  logic             fire;
  logic             comm_we;
  preg_t            spec_ps1;
  preg_t            spec_ps2;
  preg_t            spec_old;
  preg_t            comm_rd1;
  preg_t            comm_rd2;
  logic [NA*PW-1:0] spec_flat;
  logic [NA*PW-1:0] comm_flat;
  logic [NA*PW-1:0] comm_next;
  logic             unused_ports;

  assign slot_free  = ~out_valid | ~out_stall;
  assign rn_ready   = slot_free & ~flush & ~(rn_rd_we & fl_full);
  assign fire       = rn_valid & rn_ready & gwe;
  assign fl_alloc   = fire & rn_rd_we;
  // The free list qualifies dealloc with gwe itself, so it is left ungated here.
  assign fl_dealloc = cm_valid & cm_rd_we;
  assign comm_we    = fl_dealloc & gwe;

  // Committed map as it will stand after this edge, so a flush sees the commit.
  always_comb begin
    comm_next = comm_flat;
    if (comm_we) begin
      comm_next[int'(cm_rd)*PW +: PW] = cm_pd;
    end
  end

  lc4_map_table u_spec (
    .clk       (clk),
    .rst       (rst),
    .load      (gwe & flush),
    .load_data (comm_next),
    .we        (fl_alloc),
    .waddr     (rn_rd),
    .wdata     (fl_next),
    .raddr0    (rn_rs1),
    .raddr1    (rn_rs2),
    .raddr2    (rn_rd),
    .rdata0    (spec_ps1),
    .rdata1    (spec_ps2),
    .rdata2    (spec_old),
    .contents  (spec_flat)
  );

  lc4_map_table u_comm (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .we        (comm_we),
    .waddr     (cm_rd),
    .wdata     (cm_pd),
    .raddr0    (cm_rd),
    .raddr1    (cm_rd),
    .raddr2    (cm_rd),
    .rdata0    (fl_cpr),
    .rdata1    (comm_rd1),
    .rdata2    (comm_rd2),
    .contents  (comm_flat)
  );

  assign unused_ports = ^{spec_flat, comm_rd1, comm_rd2};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_ps1    <= '0;
      out_ps2    <= '0;
      out_pd     <= '0;
      out_old_pd <= '0;
      out_rd_we  <= 1'b0;
    end else if (gwe) begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (fire) begin
        out_valid  <= 1'b1;
        out_ps1    <= spec_ps1;
        out_ps2    <= spec_ps2;
        out_pd     <= rn_rd_we ? fl_next : '0;
        out_old_pd <= spec_old;
        out_rd_we  <= rn_rd_we;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lc4_rename_table.sv
// Scoreboard bench for lc4_rename_table against an array-based map model.
`default_nettype none

module tb_lc4_rename_table;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       gwe = 1'b0, flush = 1'b0;
  logic       rn_valid = 1'b0, rn_rd_we = 1'b0, rn_ready;
  logic [2:0] rn_rs1 = '0, rn_rs2 = '0, rn_rd = '0;
  logic [3:0] fl_next = '0;
  logic       fl_full = 1'b0, fl_alloc;
  logic       out_valid, out_stall = 1'b0, out_rd_we;
  logic [3:0] out_ps1, out_ps2, out_pd, out_old_pd;
  logic       cm_valid = 1'b0, cm_rd_we = 1'b0, fl_dealloc;
  logic [2:0] cm_rd = '0;
  logic [3:0] cm_pd = '0, fl_cpr;

  lc4_rename_table dut (
    .clk(clk), .rst(rst), .gwe(gwe), .flush(flush),
    .rn_valid(rn_valid), .rn_rs1(rn_rs1), .rn_rs2(rn_rs2), .rn_rd(rn_rd),
    .rn_rd_we(rn_rd_we), .rn_ready(rn_ready),
    .fl_next(fl_next), .fl_full(fl_full), .fl_alloc(fl_alloc),
    .out_valid(out_valid), .out_stall(out_stall), .out_ps1(out_ps1),
    .out_ps2(out_ps2), .out_pd(out_pd), .out_old_pd(out_old_pd),
    .out_rd_we(out_rd_we),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_pd(cm_pd), .cm_rd_we(cm_rd_we),
    .fl_dealloc(fl_dealloc), .fl_cpr(fl_cpr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ps1;
    logic [3:0] ps2;
    logic [3:0] pd;
    logic [3:0] old_pd;
    logic       rd_we;
  } beat_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t exp_q[$];
  int    spec_m[8];
  int    comm_m[8];
  bit    m_valid;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      spec_m[i] = i;
      comm_m[i] = i;
    end
    m_valid = 0;
    exp_q.delete();
  endtask

  // Evaluated mid-cycle with stable inputs: checks combinational outputs,
  // queues the expected beat, then advances the model past the coming edge.
  task automatic model_cycle();
    bit slot, rdy, f;
    slot = !m_valid || !out_stall;
    rdy  = slot && !flush && !(rn_rd_we && fl_full);
    f    = rn_valid && rdy && gwe;
    chk("rn_ready", int'(rn_ready), int'(rdy));
    chk("fl_alloc", int'(fl_alloc), int'(f && rn_rd_we));
    chk("fl_dealloc", int'(fl_dealloc), int'(cm_valid && cm_rd_we));
    chk("fl_cpr", int'(fl_cpr), comm_m[cm_rd]);
    if (f)
      exp_q.push_back('{ps1: 4'(spec_m[rn_rs1]), ps2: 4'(spec_m[rn_rs2]),
                         pd: rn_rd_we ? fl_next : 4'd0,
                         old_pd: 4'(spec_m[rn_rd]), rd_we: rn_rd_we});
    if (gwe) begin
      if (f && rn_rd_we) spec_m[rn_rd] = int'(fl_next);
      if (cm_valid && cm_rd_we) comm_m[cm_rd] = int'(cm_pd);
      if (flush) spec_m = comm_m;
      if (flush) m_valid = 0;
      else if (f) m_valid = 1;
      else if (slot) m_valid = 0;
    end
  endtask

  task automatic step(input bit v, input int rs1, input int rs2, input int rd,
                      input bit we, input int nxt, input bit full, input bit stall,
                      input bit cv, input int crd, input int cpd, input bit cwe,
                      input bit fl, input bit g);
    @(posedge clk);
    #1;
    rn_valid = v; rn_rs1 = 3'(rs1); rn_rs2 = 3'(rs2); rn_rd = 3'(rd);
    rn_rd_we = we; fl_next = 4'(nxt); fl_full = full; out_stall = stall;
    cm_valid = cv; cm_rd = 3'(crd); cm_pd = 4'(cpd); cm_rd_we = cwe;
    flush = fl; gwe = g;
    @(negedge clk);
    model_cycle();
  endtask

  // Monitor: each new beat pops one expectation; a beat held by stall or gwe
  // low must reappear unchanged on the following cycle.
  beat_t cur;
  bit    held = 0;
  always @(negedge clk) begin
    if (!rst) begin
      held <= 0;
    end else if (out_valid) begin
      if (!held) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
        end
      end
      chk("out_ps1", int'(out_ps1), int'(cur.ps1));
      chk("out_ps2", int'(out_ps2), int'(cur.ps2));
      chk("out_pd", int'(out_pd), int'(cur.pd));
      chk("out_old_pd", int'(out_old_pd), int'(cur.old_pd));
      chk("out_rd_we", int'(out_rd_we), int'(cur.rd_we));
      held <= out_stall || !gwe;
    end else begin
      held <= 0;
    end
  end

  initial begin
    model_reset();
    cm_rd = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_fields", int'({out_ps1, out_ps2, out_pd, out_old_pd, out_rd_we}), 0);
    chk("rst_fl_cpr", int'(fl_cpr), 5);
    rst = 1'b1;

    //   v rs1 rs2 rd we nxt full stl cv crd cpd cwe fl g
    step(1, 3, 5, 2, 1, 8, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 2, 0, 2, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 2, 3, 1, 10, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) step(1, 3, 3, 4, 1, 11, 0, 1, 0, 0, 0, 0, 0, 1);
    step(1, 3, 3, 4, 0, 11, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 8, 1, 0, 1);
    step(1, 0, 0, 4, 1, 10, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 4, 4, 4, 1, 12, 0, 0, 1, 4, 11, 1, 1, 1);
    step(1, 4, 2, 5, 1, 13, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 4, 2, 5, 1, 13, 0, 0, 0, 4, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a flush cycle, between clock edges.
    @(posedge clk);
    #1;
    flush = 1'b1; rn_valid = 1'b0; cm_valid = 1'b0; cm_rd = 3'd4;
    #1;
    chk("pre_reset_cpr", int'(fl_cpr), comm_m[4]);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_cpr", int'(fl_cpr), 4);
    chk("async_rst_valid", int'(out_valid), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 99) < 75, $urandom_range(0, 15),
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 40, $urandom_range(0, 7), $urandom_range(0, 15),
           $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 90);
    end
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
